// File: rtl/rv32_alu_pkg.sv
// Shared types for the sequential RV32I ALU: op codes, FSM states, default width.
package rv32_alu_pkg;

  localparam int unsigned XlenDefault = 32;

  typedef enum logic [3:0] {
    AluAdd  = 4'b0000,
    AluSub  = 4'b0001,
    AluAnd  = 4'b0010,
    AluOr   = 4'b0011,
    AluXor  = 4'b0100,
    AluSlt  = 4'b0101,
    AluSltu = 4'b0110,
    AluSll  = 4'b0111,
    AluSra  = 4'b1000,
    AluSrl  = 4'b1001
  } alu_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } alu_state_t;

endpackage

// File: rtl/rv32_shift_unit.sv
// Shifter for rv32_alu_seq: iterative 1 bit/cycle, or a barrel shifter when
// RV32_ALU_FAST_SHIFT_EN is defined (then res is a pure function of op/data/shamt).
module rv32_shift_unit
  import rv32_alu_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     step,
  input  alu_op_t                  op,
  input  logic [XLEN-1:0]          data,
  input  logic [$clog2(XLEN)-1:0]  shamt,
  output logic [XLEN-1:0]          res,
  output logic                     last
);

`ifdef RV32_ALU_FAST_SHIFT_EN

  always_comb begin
    res = '0;
    case (op)
      AluSll:  res = data << shamt;
      AluSra:  res = $signed(data) >>> shamt;
      default: res = data >> shamt;
    endcase
  end

  assign last = 1'b1;

  logic unused_fast;
  assign unused_fast = ^{clk, rst, load, step};

`else

  localparam int unsigned ShW = $clog2(XLEN);

  alu_op_t         op_q;
  logic [XLEN-1:0] sreg_q;
  logic [ShW-1:0]  cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= AluSll;
      sreg_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      op_q   <= op;
      sreg_q <= data;
      cnt_q  <= shamt;
    end else if (step) begin
      sreg_q <= res;
      cnt_q  <= cnt_q - 1'b1;
    end
  end

  // res is the value after this cycle's one-bit shift
  always_comb begin
    res = '0;
    case (op_q)
      AluSll:  res = {sreg_q[XLEN-2:0], 1'b0};
      AluSra:  res = {sreg_q[XLEN-1], sreg_q[XLEN-1:1]};
      default: res = {1'b0, sreg_q[XLEN-1:1]};
    endcase
  end

  assign last = (cnt_q == ShW'(1));

`endif

endmodule

// File: rtl/rv32_alu_seq.sv
// Multi-cycle RV32I ALU with valid/ready handshakes on both sides.
// Define RV32_ALU_FAST_SHIFT_EN for single-cycle barrel shifts.
module rv32_alu_seq
  import rv32_alu_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int unsigned ShW = $clog2(XLEN);

  alu_state_t      state_q, state_d;
  alu_op_t         op;
  logic            accept, op_shift, op_legal;
  logic [ShW-1:0]  shamt;
  logic [XLEN-1:0] alu_res, sh_res;
  logic            sh_load, sh_step, sh_last;
  logic            load_res, illegal_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, illegal_q;

  assign op       = alu_op_t'(alu_op);
  assign accept   = in_valid && in_ready;
  assign shamt    = b[ShW-1:0];
  assign op_shift = op inside {AluSll, AluSra, AluSrl};
  assign op_legal = (alu_op <= 4'b1001);

  // Shift ops fall through to `a`, which is the shamt == 0 result
  always_comb begin
    alu_res = '0;
    case (op)
      AluAdd:  alu_res = a + b;
      AluSub:  alu_res = a - b;
      AluAnd:  alu_res = a & b;
      AluOr:   alu_res = a | b;
      AluXor:  alu_res = a ^ b;
      AluSlt:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      AluSltu: alu_res = {{(XLEN-1){1'b0}}, a < b};
      AluSll, AluSra, AluSrl: alu_res = a;
      default: alu_res = '0;
    endcase
  end

  rv32_shift_unit #(
    .XLEN (XLEN)
  ) u_shift (
    .clk   (clk),
    .rst   (rst),
    .load  (sh_load),
    .step  (sh_step),
    .op    (op),
    .data  (a),
    .shamt (shamt),
    .res   (sh_res),
    .last  (sh_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
`ifdef RV32_ALU_FAST_SHIFT_EN
          state_d = StDone;
`else
          state_d = (op_shift && shamt != '0) ? StShift : StDone;
`endif
        end
      end
      StShift: if (sh_last) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    sh_load   = 1'b0;
    sh_step   = (state_q == StShift);
    load_res  = 1'b0;
    result_d  = alu_res;
    illegal_d = !op_legal;
    case (state_q)
      StIdle: begin
        if (accept) begin
          sh_load = op_shift;
`ifdef RV32_ALU_FAST_SHIFT_EN
          load_res = 1'b1;
          if (op_shift) result_d = sh_res;
`else
          load_res = !op_shift || (shamt == '0);
`endif
        end
      end
      StShift: begin
        load_res  = sh_last;
        result_d  = sh_res;
        illegal_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Result flags are registered so they stay stable across back-pressure
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else if (load_res) begin
      result_q  <= result_d;
      zero_q    <= (result_d == '0);
      illegal_q <= illegal_d;
    end
  end

  assign result  = result_q;
  assign zero    = zero_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_rv32_alu_seq.sv
// Self-checking bench for rv32_alu_seq: directed vector table, handshake/reset
// sequences, and random ops against a behavioural model.
module tb_rv32_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rv32_alu_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  typedef struct {
    string       nm;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic ill);
    int sh;
    logic signed [31:0] sx;
    sh  = int'(y[4:0]);
    sx  = x;
    ill = 1'b0;
    case (op)
      4'd0: r = x + y;
      4'd1: r = x - y;
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd6: r = (x < y) ? 32'd1 : 32'd0;
      4'd7: r = x << sh;
      4'd8: r = sx >>> sh;
      4'd9: r = x >> sh;
      default: begin
        r   = 32'd0;
        ill = 1'b1;
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [31:0] y);
`ifdef RV32_ALU_FAST_SHIFT_EN
    return 0;
`else
    return (op >= 4'd7 && op <= 4'd9) ? int'(y[4:0]) : 0;
`endif
  endfunction

  // One complete transaction with out_ready held high
  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] er, input logic eill);
    int lat;
    @(negedge clk);
    check({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    alu_op    = op;
    a         = av;
    b         = bv;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    alu_op   = 4'($urandom);
    a        = $urandom;
    b        = $urandom;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      check({nm, "_timeout"}, 32'(out_valid), 32'd1);
    end else begin
      check({nm, "_latency"}, 32'(lat), 32'(exp_lat(op, bv)));
      check({nm, "_result"}, result, er);
      check({nm, "_zero"}, 32'(zero), 32'(er == 32'd0));
      check({nm, "_illegal"}, 32'(illegal), 32'(eill));
      @(negedge clk);
      check({nm, "_done_1cyc"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] er;
    logic        eill;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    int          stale;

    tbl[0]  = '{"add_wrap",   4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0};
    tbl[1]  = '{"sub_eq",     4'h1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0};
    tbl[2]  = '{"slt_neg",    4'h5, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
    tbl[3]  = '{"sltu_big",   4'h6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0};
    tbl[4]  = '{"sra_4",      4'h8, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0};
    tbl[5]  = '{"sll_0",      4'h7, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b0};
    tbl[6]  = '{"op_f",       4'hF, 32'hDEAD_BEEF, 32'h0000_0003, 32'h0000_0000, 1'b1};
    tbl[7]  = '{"and_after",  4'h2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
    tbl[8]  = '{"or",         4'h3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0};
    tbl[9]  = '{"xor",        4'h4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0};
    tbl[10] = '{"srl_31",     4'h9, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0};
    tbl[11] = '{"sll_31",     4'h7, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0};
    tbl[12] = '{"sra_hi_b",   4'h8, 32'h7FFF_FFFF, 32'hFFFF_FFE1, 32'h3FFF_FFFF, 1'b0};
    tbl[13] = '{"op_a",       4'hA, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1};
    tbl[14] = '{"sub_wrap",   4'h1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);

    foreach (tbl[i]) run_op(tbl[i].nm, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].ill);

    // Back-pressure: result held, new requests ignored, then accept on the next edge
    @(negedge clk);
    out_ready = 1'b0;
    alu_op = 4'h1; a = 32'd9; b = 32'd4; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    alu_op = 4'h0; a = 32'd1; b = 32'd2;
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_result", result, 32'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_result", result, 32'd5);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_acc_valid", 32'(out_valid), 32'd0);
    check("bp_acc_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_result", result, 32'd3);
    @(negedge clk);
    check("bp_next_drained", 32'(out_valid), 32'd0);

    // Reset in the middle of a long shift
    alu_op = 4'h9; a = 32'hFFFF_FFFF; b = 32'd31; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_illegal", 32'(illegal), 32'd0);
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("mid_rst_no_stale", 32'(stale), 32'd0);

    // Random ops against the model
    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = $urandom;
      if (i % 4 == 0) rb = rb & 32'h0000_0003;
      model(rop, ra, rb, er, eill);
      run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, er, eill);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32_alu_seq.md
# rv32_alu_seq

Multi-cycle RV32I integer ALU that consumes the 4-bit `alu_op` code produced by the ALU control decoder and executes it on two 32-bit operands. It sits in the execute stage and exchanges operands and results over valid/ready handshakes, so the pipeline can stall on long shifts. Logic and arithmetic ops complete in one cycle. Shifts are iterative, one bit per cycle, unless fast shift is compiled in.

## Interface
- `XLEN`, default 32: operand/result width; shift amount is `b[$clog2(XLEN)-1:0]`.
- `clk  input  1`: single clock; all state updates on rising edge.
- `rst  input  1`: reset, synchronous and active-high.
- `in_valid  input  1`: operands and op are valid.
- `in_ready  output  1`: ALU can accept; high only in IDLE.
- `alu_op  input  4`: operation code (encoding below).
- `a  input  XLEN`: operand A (rs1).
- `b  input  XLEN`: operand B (rs2/immediate; low 5 bits = shamt).
- `out_valid  output  1`: result valid; held until accepted.
- `out_ready  input  1`: consumer accepts result.
- `result  output  XLEN`: registered result.
- `zero  output  1`: `result == 0`; used for branch compare after SUB.
- `illegal  output  1`: captured op was not a defined code.

## Operation
- Encoding: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed), 0110 SLTU, 0111 SLL, 1000 SRA, 1001 SRL; 1010–1111 invalid.
- Accept occurs on `in_valid && in_ready`. Inputs `a`, `b`, and `alu_op` are captured at that edge and may change afterward.
- ADD/SUB wrap modulo 2^XLEN. No overflow flag.
- SLT/SLTU return 1 or 0 in bit 0; upper bits are 0.
- Invalid op: `result = 0`, `zero = 1`, `illegal = 1`. Takes the non-shift path.
- FSM states:
  - IDLE: on accept, a non-shift op computes its result and goes to DONE. A shift op loads the shift register with `a` and the counter with shamt. If shamt == 0 it goes to DONE; otherwise it goes to SHIFT.
  - SHIFT: each cycle shifts one bit (SLL: zero-fill left; SRL: zero-fill right; SRA: sign-fill right) and decrements the counter. When the counter reaches 1, that shift completes and the FSM goes to DONE.
  - DONE: `out_valid = 1`. When `out_ready` is high, go to IDLE.
- `result`, `zero`, and `illegal` are stable for the whole time `out_valid` is high.
- Any `in_valid` outside IDLE is ignored; `in_ready` is low then.

## Timing
- Reset (sync, `rst` high at the edge) forces IDLE and clears all state. Outputs after reset: `in_ready = 1`, `out_valid = 0`, `result = 0`, `zero = 0`, `illegal = 0`.
- Reset mid-operation, in SHIFT or DONE, aborts the operation. The pending result is discarded, and the next cycle is IDLE.
- Latency, for an accept at edge N:
  - Non-shift ops and shamt 0: `out_valid` rises at N+1.
  - Shift with shamt k ≥ 1: `out_valid` rises at N+1+k (max N+32).
- Result accepted at edge M: `out_valid` is low and `in_ready` is high after M. The next accept is possible at M+1, giving a throughput of one op per ≥2 cycles.
- `out_ready` held high while waiting: DONE lasts exactly one cycle.

## Configuration
- `RV32_ALU_FAST_SHIFT_EN` defined: shifts use a combinational barrel shifter, SHIFT is unused, and every op has latency 1.
- Not defined: iterative 1-bit/cycle shifter as specified above (smaller area).
- Handshake and result values are identical in both builds; only latency differs.

## Structure
- Package `rv32_alu_pkg`:
  - `alu_op_t` enum with the ten codes; shared with the ALU control decoder.
  - FSM state enum.
  - `XLEN` default.
- Sub-module `rv32_shift_unit`: holds the shift register, counter, and direction/fill logic. It is built as a barrel shifter under `RV32_ALU_FAST_SHIFT_EN`. The top level keeps the FSM, handshake, and add/logic/compare datapath.

## Test plan
- ADD with a=0x7FFFFFFF, b=1 → result 0x80000000 at N+1. SUB with a=5, b=5 → result 0, zero=1.
- SLT with a=0xFFFFFFFF, b=1 → 1. SLTU on the same operands → 0.
- SRA with a=0x80000000, b=4 → 0xF8000000, out_valid at N+5 (N+1 with FAST). SLL with shamt 0 → a unchanged at N+1.
- alu_op=1111 → result 0, illegal=1, zero=1. Next valid op clears `illegal`.
- Back-pressure: hold `out_ready` low for 3 cycles after a result → result stable, `in_ready` low, `in_valid` ignored. Accept, then a new op is accepted at the next edge.
- Assert `rst` during SRL with shamt 31 at cycle 10 → next cycle IDLE, out_valid=0, result=0, and no stale result appears.
